bcd_counter_multi: RTL and testbench

Parametrised multi-digit BCD up/down counter. Cascades DIGITS decimal digits through an internal carry/borrow chain. Supports synchronous parallel load, enable, direction control, and wrap or saturate mode at the terminal value. Includes a sticky overflow flag. Intended as the general counter for display, timer and event-count paths in the lab designs, replacing single-digit counters.

---
 rtl/bcd_pkg.sv | 23 ++
 rtl/bcd_digit.sv | 40 ++++
 rtl/bcd_counter_multi.sv | 65 ++++++
 tb/tb_bcd_counter_multi.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD constants and digit helpers used by the multi-digit counter
// and its per-digit cells.
package bcd_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

  function automatic logic is_bcd(input logic [BCD_W-1:0] digit);
    return digit <= BCD_MAX;
  endfunction

  // Bit offset of digit idx inside a packed multi-digit vector.
  function automatic int digit_lsb(input int idx);
    return idx * BCD_W;
  endfunction

  // Non-BCD digits collapse to zero.
  function automatic logic [BCD_W-1:0] sanitize(input logic [BCD_W-1:0] digit);
    return is_bcd(digit) ? digit : BCD_MIN;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the cascaded counter: load, step up/down with
// wrap inside the digit, and a terminal flag for the carry/borrow chain.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             ld,
  input  logic [BCD_W-1:0] ld_val,
  input  logic             en,
  input  logic             up,
  input  logic             sat_hold,
  output logic [BCD_W-1:0] q,
  output logic             tc
);

  function automatic logic [BCD_W-1:0] step_digit(input logic [BCD_W-1:0] cur,
                                                  input logic dir_up);
    logic [BCD_W-1:0] nxt;
    if (!is_bcd(cur))
      nxt = BCD_MIN;
    else if (dir_up)
      nxt = (cur == BCD_MAX) ? BCD_MIN : cur + 4'd1;
    else
      nxt = (cur == BCD_MIN) ? BCD_MAX : cur - 4'd1;
    return nxt;
  endfunction

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)
      q <= BCD_MIN;
    else if (ld)
      q <= sanitize(ld_val);
    else if (en && !sat_hold)
      q <= step_digit(q, up);
  end

  assign tc = up ? (q == BCD_MAX) : (q == BCD_MIN);

endmodule

// File: rtl/bcd_counter_multi.sv
// Multi-digit BCD up/down counter: digits cascade through an enable chain,
// with wrap/saturate at the terminal value, sticky overflow and load error.
module bcd_counter_multi
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SATURATE = 0
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [4*DIGITS-1:0]   d,
  input  logic                  load,
  input  logic                  enable,
  input  logic                  up,
  output logic [4*DIGITS-1:0]   q,
  output logic                  co,
  output logic                  ovf,
  output logic                  load_err
);

  logic [DIGITS-1:0] tc;
  logic [DIGITS-1:0] chain_en;
  logic [DIGITS-1:0] bad_digit;
  logic              sat_hold;

  // Digit i steps only when every lower digit is at its terminal value.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (i == 0) begin : g_first
      assign chain_en[i] = enable;
    end else begin : g_rest
      assign chain_en[i] = chain_en[i-1] & tc[i-1];
    end

    assign bad_digit[i] = ~is_bcd(d[digit_lsb(i) +: BCD_W]);

    bcd_digit u_digit (
      .clk      (clk),
      .clr      (clr),
      .ld       (load),
      .ld_val   (d[digit_lsb(i) +: BCD_W]),
      .en       (chain_en[i]),
      .up       (up),
      .sat_hold (sat_hold),
      .q        (q[digit_lsb(i) +: BCD_W]),
      .tc       (tc[i])
    );
  end

  assign co       = enable & ~load & (&tc);
  assign sat_hold = (SATURATE != 0) && co;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ovf      <= 1'b0;
      load_err <= 1'b0;
    end else begin
      load_err <= load & (|bad_digit);
      if (load)
        ovf <= 1'b0;
      else if (co)
        ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_counter_multi.sv
// Scoreboard bench: a 4-digit wrapping counter and a 2-digit saturating
// counter share stimulus; an integer-valued model predicts both.
module tb_bcd_counter_multi;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] d = '0;
  logic        load = 1'b0;
  logic        enable = 1'b0;
  logic        up = 1'b1;

  logic [15:0] q_w;
  logic [7:0]  q_s;
  logic        co_w, ovf_w, err_w;
  logic        co_s, ovf_s, err_s;

  bcd_counter_multi #(.DIGITS(4), .SATURATE(0)) dut_w (
    .clk(clk), .clr(clr), .d(d), .load(load), .enable(enable), .up(up),
    .q(q_w), .co(co_w), .ovf(ovf_w), .load_err(err_w)
  );

  bcd_counter_multi #(.DIGITS(2), .SATURATE(1)) dut_s (
    .clk(clk), .clr(clr), .d(d[7:0]), .load(load), .enable(enable), .up(up),
    .q(q_s), .co(co_s), .ovf(ovf_s), .load_err(err_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] qpre_w;
    logic [7:0]  qpre_s;
    logic        ovfpre_w, ovfpre_s;
    logic        co_w, co_s;
    logic [15:0] q_w;
    logic [7:0]  q_s;
    logic        ovf_w, ovf_s, err_w, err_s;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int mv_w = 0, mv_s = 0;
  bit mo_w = 0, mo_s = 0;

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    int t = v;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int load_val(input logic [15:0] dv, input int nd, output bit err);
    int v = 0;
    int dig;
    err = 0;
    for (int i = 0; i < nd; i++) begin
      dig = int'((dv >> (4*i)) & 16'hF);
      if (dig > 9) err = 1;
      else v = v + dig * pow10(i);
    end
    return v;
  endfunction

  task automatic model_step(inout int v, inout bit o, input int nd, input bit sat,
                            input bit ld, input bit en, input bit u, input logic [15:0] dv,
                            output bit co_o, output bit err);
    int maxv = pow10(nd) - 1;
    co_o = en && !ld && ((u && v == maxv) || (!u && v == 0));
    err = 0;
    if (ld) begin
      v = load_val(dv, nd, err);
      o = 0;
    end else if (en) begin
      if (co_o) begin
        o = 1;
        if (!sat) v = u ? 0 : maxv;
      end else begin
        v = u ? v + 1 : v - 1;
      end
    end
  endtask

  task automatic drive(input bit c_pulse, input bit ld, input bit en, input bit u,
                       input logic [15:0] dv);
    exp_t e;
    bit   c, er;
    @(negedge clk);
    #1;
    load = ld; enable = en; up = u; d = dv;
    if (c_pulse) begin
      clr = 1'b0;
      mv_w = 0; mv_s = 0; mo_w = 0; mo_s = 0;
      #1 clr = 1'b1;
    end
    e.qpre_w   = to_bcd(mv_w);
    e.qpre_s   = 8'(to_bcd(mv_s));
    e.ovfpre_w = mo_w;
    e.ovfpre_s = mo_s;
    model_step(mv_w, mo_w, 4, 1'b0, ld, en, u, dv, c, er);
    e.co_w = c; e.err_w = er;
    model_step(mv_s, mo_s, 2, 1'b1, ld, en, u, dv, c, er);
    e.co_s = c; e.err_s = er;
    e.q_w   = to_bcd(mv_w);
    e.q_s   = 8'(to_bcd(mv_s));
    e.ovf_w = mo_w;
    e.ovf_s = mo_s;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pre-edge values mid-cycle, post-edge values just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("q_w_pre",   32'(q_w),   32'(e.qpre_w));
        chk("q_s_pre",   32'(q_s),   32'(e.qpre_s));
        chk("ovf_w_pre", 32'(ovf_w), 32'(e.ovfpre_w));
        chk("ovf_s_pre", 32'(ovf_s), 32'(e.ovfpre_s));
        chk("co_w",      32'(co_w),  32'(e.co_w));
        chk("co_s",      32'(co_s),  32'(e.co_s));
        @(posedge clk);
        #1;
        chk("q_w",   32'(q_w),   32'(e.q_w));
        chk("q_s",   32'(q_s),   32'(e.q_s));
        chk("ovf_w", 32'(ovf_w), 32'(e.ovf_w));
        chk("ovf_s", 32'(ovf_s), 32'(e.ovf_s));
        chk("err_w", 32'(err_w), 32'(e.err_w));
        chk("err_s", 32'(err_s), 32'(e.err_s));
      end
    end
  end

  logic [15:0] corner [6] = '{16'h9999, 16'h0000, 16'h9998, 16'h0001, 16'h0099, 16'h99AF};

  initial begin
    int r;
    int budget;
    logic [15:0] dv;
    repeat (2) @(negedge clk);
    clr = 1'b1;

    drive(1, 0, 0, 1, 16'h0000);
    drive(0, 1, 1, 1, 16'h0008);
    repeat (3) drive(0, 0, 1, 1, 16'h0000);
    drive(0, 1, 0, 1, 16'h9998);
    repeat (2) drive(0, 0, 1, 1, 16'h0000);
    repeat (4) drive(0, 0, 1, 0, 16'h0000);
    drive(0, 1, 1, 0, 16'h0001);
    repeat (3) drive(0, 0, 1, 0, 16'h0000);
    drive(0, 1, 0, 1, 16'h003C);
    drive(0, 0, 0, 1, 16'h0000);
    drive(0, 1, 0, 1, 16'h0999);
    drive(0, 0, 1, 1, 16'h0000);
    drive(0, 0, 1, 0, 16'h0000);
    drive(0, 1, 0, 1, 16'h0037);
    drive(1, 0, 1, 1, 16'h0000);
    drive(0, 0, 1, 1, 16'h0000);

    for (int n = 0; n < 500; n++) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 1) == 1) dv = 16'($urandom);
      else dv = corner[$urandom_range(0, 5)];
      drive(r < 3, (r >= 3 && r < 15), $urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)), dv);
    end

    drive(0, 0, 0, 1, 16'h0000);
    budget = 0;
    while (sb.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
